// File: rtl/matrix_op_sequencer_if.sv
// Bundle of the command, operand-load, result-read and ALU signals of
// matrix_op_sequencer.
//   master : command source / operand loader / external ALU side
//   slave  : the sequencer itself
// Signals:
//   start, op[2:0], size[2:0], scalar  command strobe and its arguments
//   load_we, load_sel, load_addr, load_data  operand write port (A/B)
//   rd_addr, rd_data                    result (C) read port
//   alu_op, alu_r1, alu_r2, alu_s       operands/opcode to the ALU
//   alu_outr                            ALU result
//   busy, done, err                     status
interface matrix_op_sequencer_if #(
  parameter int MAXN = 5,
  parameter int DW   = 8
);
  localparam int AW = $clog2(MAXN * MAXN);

  logic                 start;
  logic [2:0]           op;
  logic [2:0]           size;
  logic signed [DW-1:0] scalar;
  logic                 load_we;
  logic                 load_sel;
  logic [AW-1:0]        load_addr;
  logic signed [DW-1:0] load_data;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_data;
  logic [2:0]           alu_op;
  logic signed [DW-1:0] alu_r1;
  logic signed [DW-1:0] alu_r2;
  logic [2:0]           alu_s;
  logic signed [DW-1:0] alu_outr;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, op, size, scalar, load_we, load_sel, load_addr, load_data,
           rd_addr, alu_outr,
    input  rd_data, alu_op, alu_r1, alu_r2, alu_s, busy, done, err
  );

  modport slave (
    input  start, op, size, scalar, load_we, load_sel, load_addr, load_data,
           rd_addr, alu_outr,
    output rd_data, alu_op, alu_r1, alu_r2, alu_s, busy, done, err
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Sequential front-end for the combinational matrix ALU. Holds operand
// matrices A, B and result matrix C (MAXN*MAXN entries each, row-major,
// address = row*MAXN + col). A start command walks the N x N element indices,
// drives the ALU each cycle and stores the ALU result into C. Matrix multiply
// accumulates the per-k ALU products locally.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    matrix_op_sequencer_if.slave (command, load, read, ALU, status)
module matrix_op_sequencer #(
  parameter int MAXN = 5,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_op_sequencer_if.slave bus
);

  localparam int DEPTH = MAXN * MAXN;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_MULR = 3'b011;
  localparam logic [2:0] OP_DET  = 3'b100;
  localparam logic [2:0] OP_TRN  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_RST  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, size_q;
  logic signed [DW-1:0] scalar_q;
  logic [2:0]           i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [DW-1:0] acc_q, acc_d;

  logic signed [DW-1:0] a_q [DEPTH];
  logic signed [DW-1:0] b_q [DEPTH];
  logic signed [DW-1:0] c_q [DEPTH];

  logic                 size_ok;
  logic [2:0]           nm1;
  logic                 last_i, last_j, last_k;
  logic                 latch_cmd, ld_en, adv;
  logic                 c_we, c_clr;
  logic [AW-1:0]        c_waddr;
  logic signed [DW-1:0] c_wdata;
  logic signed [DW-1:0] sum;

  function automatic logic [AW-1:0] addr_of(input logic [2:0] row,
                                            input logic [2:0] col);
    return AW'(row) * AW'(MAXN) + AW'(col);
  endfunction

  assign size_ok = (size_q != 3'd0) && (int'(size_q) <= MAXN);
  assign nm1     = size_q - 3'd1;
  assign last_i  = (i_q == nm1);
  assign last_j  = (j_q == nm1);
  assign last_k  = (k_q == nm1);

  // Next-state, index stepping and C write control.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    acc_d     = acc_q;
    latch_cmd = 1'b0;
    ld_en     = 1'b0;
    adv       = 1'b0;
    c_we      = 1'b0;
    c_clr     = 1'b0;
    c_waddr   = '0;
    c_wdata   = '0;
    sum       = '0;

    case (state_q)
      S_IDLE: begin
        ld_en = bus.load_we && (bus.load_addr <= LAST_ADDR);
        if (bus.start) begin
          latch_cmd = 1'b1;
          state_d   = S_RUN;
          i_d       = 3'd0;
          j_d       = 3'd0;
          k_d       = 3'd0;
        end
      end

      S_RUN: begin
        // An invalid size still spends one busy cycle here so the command
        // is visibly accepted, but nothing is written to C.
        if (!size_ok) begin
          state_d = S_FIN;
        end else begin
          case (op_q)
            OP_MUL: begin
              sum   = (k_q == 3'd0) ? bus.alu_outr : acc_q + bus.alu_outr;
              acc_d = sum;
              if (last_k) begin
                c_we    = 1'b1;
                c_waddr = addr_of(i_q, j_q);
                c_wdata = sum;
                k_d     = 3'd0;
                adv     = 1'b1;
              end else begin
                k_d = k_q + 3'd1;
              end
            end
            OP_DET: begin
              c_we    = 1'b1;
              c_waddr = '0;
              c_wdata = bus.alu_outr;
              state_d = S_FIN;
            end
            OP_RST: begin
              c_clr   = 1'b1;
              state_d = S_FIN;
            end
            OP_ADD, OP_SUB, OP_MULR, OP_TRN, OP_NEG: begin
              c_we    = 1'b1;
              c_waddr = addr_of(i_q, j_q);
              c_wdata = bus.alu_outr;
              adv     = 1'b1;
            end
            default: state_d = S_FIN;
          endcase
        end

        // Row-major walk: j inner, i outer; wrapping the last element ends RUN.
        if (adv) begin
          if (last_j) begin
            j_d = 3'd0;
            if (last_i) begin
              i_d     = 3'd0;
              state_d = S_FIN;
            end else begin
              i_d = i_q + 3'd1;
            end
          end else begin
            j_d = j_q + 3'd1;
          end
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status and ALU operand mux.
  always_comb begin
    bus.busy   = (state_q == S_RUN);
    bus.done   = (state_q == S_FIN);
    bus.err    = (state_q == S_FIN) && !size_ok;
    bus.alu_op = bus.busy ? op_q   : 3'd0;
    bus.alu_s  = bus.busy ? size_q : 3'd0;
    bus.alu_r1 = '0;
    bus.alu_r2 = '0;
    if (bus.busy && size_ok) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          bus.alu_r1 = a_q[addr_of(i_q, j_q)];
          bus.alu_r2 = b_q[addr_of(i_q, j_q)];
        end
        OP_MUL: begin
          bus.alu_r1 = a_q[addr_of(i_q, k_q)];
          bus.alu_r2 = b_q[addr_of(k_q, j_q)];
        end
        OP_MULR: begin
          bus.alu_r1 = a_q[addr_of(i_q, j_q)];
          bus.alu_r2 = scalar_q;
        end
        OP_TRN: begin
          bus.alu_r1 = a_q[addr_of(j_q, i_q)];
          bus.alu_r2 = DW'(1);
        end
        OP_NEG: begin
          bus.alu_r1 = a_q[addr_of(i_q, j_q)];
          bus.alu_r2 = '1;
        end
        default: begin
          bus.alu_r1 = '0;
          bus.alu_r2 = '0;
        end
      endcase
    end
  end

  assign bus.rd_data = (bus.rd_addr <= LAST_ADDR) ? c_q[bus.rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      size_q   <= 3'd0;
      scalar_q <= '0;
      i_q      <= 3'd0;
      j_q      <= 3'd0;
      k_q      <= 3'd0;
      acc_q    <= '0;
    end else begin
      if (latch_cmd) begin
        op_q     <= bus.op;
        size_q   <= bus.size;
        scalar_q <= bus.scalar;
      end
      i_q   <= i_d;
      j_q   <= j_d;
      k_q   <= k_d;
      acc_q <= acc_d;
    end
  end

  // Operand and result register files. A load coinciding with start lands on
  // the same edge, before the first RUN cycle reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      if (ld_en) begin
        if (bus.load_sel) begin
          b_q[bus.load_addr] <= bus.load_data;
        end else begin
          a_q[bus.load_addr] <= bus.load_data;
        end
      end
      if (c_clr) begin
        for (int n = 0; n < DEPTH; n++) begin
          c_q[n] <= '0;
        end
      end else if (c_we) begin
        c_q[c_waddr] <= c_wdata;
      end
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a behavioural stand-in ALU.
module tb_matrix_op_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  matrix_op_sequencer_if #(.MAXN(5), .DW(8)) bus ();

  matrix_op_sequencer #(.MAXN(5), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Stand-in combinational ALU: elementwise ops reduce to add, sub or a
  // truncated product (transpose multiplies by 1, opposite by -1).
  logic signed [15:0] prod;
  always_comb begin
    prod         = bus.alu_r1 * bus.alu_r2;
    bus.alu_outr = '0;
    case (bus.alu_op)
      3'b000:  bus.alu_outr = bus.alu_r1 + bus.alu_r2;
      3'b001:  bus.alu_outr = bus.alu_r1 - bus.alu_r2;
      3'b100:  bus.alu_outr = '0;
      3'b111:  bus.alu_outr = '0;
      default: bus.alu_outr = prod[7:0];
    endcase
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic rd_c(input int addr, input int exp, input string tag);
    bus.rd_addr = 5'(addr);
    #1;
    chk(tag, int'(bus.rd_data), exp);
  endtask

  task automatic load(input logic sel, input int addr, input int data);
    bus.load_sel  = sel;
    bus.load_addr = 5'(addr);
    bus.load_data = 8'(data);
    bus.load_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load_we = 1'b0;
  endtask

  // Issues a command, then counts clock edges from the start edge (inclusive)
  // until done is seen, and checks the done/err pulse.
  task automatic run_cmd(input int o, input int s, input int sc,
                         input int exp_lat, input int exp_err, input string tag);
    int cnt;
    bus.op     = 3'(o);
    bus.size   = 3'(s);
    bus.scalar = 8'(sc);
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.load_we = 1'b0;
    chk({tag, " busy"}, int'(bus.busy), 1);
    cnt = 1;
    while (!bus.done && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, cnt, exp_lat);
    chk({tag, " err"}, int'(bus.err), exp_err);
    @(negedge clk);
    chk({tag, " done pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.size      = 3'd0;
    bus.scalar    = '0;
    bus.load_we   = 1'b0;
    bus.load_sel  = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.rd_addr   = '0;

    repeat (3) @(negedge clk);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst alu_op", int'(bus.alu_op), 0);
    chk("rst alu_s", int'(bus.alu_s), 0);
    chk("rst alu_r1", int'(bus.alu_r1), 0);
    rd_c(0, 0, "rst C0");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Add, N=2
    load(0, 0, 1);  load(0, 1, 2);  load(0, 5, 3);  load(0, 6, 4);
    load(1, 0, 10); load(1, 1, 20); load(1, 5, 30); load(1, 6, 40);
    run_cmd(0, 2, 0, 5, 0, "add");
    rd_c(0, 11, "add C0");
    rd_c(1, 22, "add C1");
    rd_c(5, 33, "add C5");
    rd_c(6, 44, "add C6");
    rd_c(2, 0, "add C2 outside");
    rd_c(30, 0, "rd addr 30");

    // Multiply, N=2
    load(1, 0, 5); load(1, 1, 6); load(1, 5, 7); load(1, 6, 8);
    bus.op = 3'd2; bus.size = 3'd2; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mul alu_op", int'(bus.alu_op), 2);
    chk("mul alu_s", int'(bus.alu_s), 2);
    bus.start = 1'b0;
    repeat (20) begin
      if (!bus.done) @(negedge clk);
    end
    chk("mul done", int'(bus.done), 1);
    @(negedge clk);
    rd_c(0, 19, "mul C0");
    rd_c(1, 22, "mul C1");
    rd_c(5, 43, "mul C5");
    rd_c(6, 50, "mul C6");
    run_cmd(2, 2, 0, 9, 0, "mul rerun");
    rd_c(6, 50, "mul rerun C6");

    // Multiply wrap and mult-by-real, N=1
    load(0, 0, 16); load(1, 0, 16);
    run_cmd(2, 1, 0, 2, 0, "mulwrap");
    rd_c(0, 0, "mulwrap C0");
    rd_c(1, 22, "mulwrap C1 outside");
    load(0, 0, -3);
    run_cmd(3, 1, 5, 2, 0, "mulr");
    rd_c(0, -15, "mulr C0");
    rd_c(5, 43, "mulr C5 outside");

    // Transpose and opposite, N=3
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        load(0, r * 5 + c, r * 3 + c);
    run_cmd(5, 3, 0, 10, 0, "trn");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        rd_c(r * 5 + c, c * 3 + r, $sformatf("trn C%0d", r * 5 + c));
    rd_c(3, 0, "trn C3 outside");
    run_cmd(6, 3, 0, 10, 0, "neg");
    rd_c(6, -4, "neg C6");
    rd_c(12, -8, "neg C12");
    rd_c(10, -6, "neg C10");

    // Invalid size with start/load pulsed while busy and in FIN
    bus.op = 3'd0; bus.size = 3'd6; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("inv busy", int'(bus.busy), 1);
    chk("inv early done", int'(bus.done), 0);
    bus.load_sel = 1'b0; bus.load_addr = 5'd0; bus.load_data = 8'sd99;
    bus.load_we  = 1'b1;
    @(negedge clk);
    chk("inv done", int'(bus.done), 1);
    chk("inv err", int'(bus.err), 1);
    chk("inv busy fin", int'(bus.busy), 0);
    bus.load_we = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("inv no restart", int'(bus.busy), 0);
    chk("inv done clear", int'(bus.done), 0);
    chk("inv err clear", int'(bus.err), 0);
    rd_c(6, -4, "inv C6 kept");
    rd_c(0, 0, "inv C0 kept");

    // A[0] must not have taken the write issued while busy
    run_cmd(6, 1, 0, 2, 0, "neg1");
    rd_c(0, 0, "neg1 C0");
    // Load coincident with start is seen by the command
    bus.load_sel = 1'b0; bus.load_addr = 5'd0; bus.load_data = 8'sd7;
    bus.load_we  = 1'b1;
    run_cmd(6, 1, 0, 2, 0, "neg1 wr");
    rd_c(0, -7, "neg1 wr C0");

    // Reset op after an add
    run_cmd(0, 2, 0, 5, 0, "add2");
    rd_c(0, 23, "add2 C0");
    rd_c(6, 12, "add2 C6");
    rd_c(10, -6, "add2 C10 outside");
    run_cmd(7, 2, 0, 2, 0, "clr");
    rd_c(0, 0, "clr C0");
    rd_c(6, 0, "clr C6");
    rd_c(10, 0, "clr C10");

    // Asynchronous reset in the middle of a multiply, N=3
    bus.op = 3'd2; bus.size = 3'd3; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst busy before", int'(bus.busy), 1);
    rd_c(0, 119, "midrst C0 before");
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst alu_op", int'(bus.alu_op), 0);
    chk("midrst alu_r1", int'(bus.alu_r1), 0);
    rd_c(0, 0, "midrst C0");
    rd_c(1, 0, "midrst C1");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // A and B were cleared too: an add over the old window yields zero
    run_cmd(0, 2, 0, 5, 0, "post rst add");
    rd_c(6, 0, "post rst C6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Sequential front-end for the combinational matrix ALU. It holds operand matrices A and B plus result matrix C in local register files. On a start command it walks the element indices of an N×N matrix (N = 1..5), drives the ALU operands and opcode each cycle, and captures the ALU result into C. Matrix multiply is supported by accumulating ALU products over k inside this block.

Parameters:
MAXN, 5, maximum matrix dimension; storage is MAXN*MAXN entries per matrix, row-major, address = row*MAXN + col
DW, 8, element width (signed two's complement)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe, sampled only in IDLE
op  in  3  opcode, same encoding as the ALU (000 add, 001 sub, 010 mult, 011 mult-by-real, 100 det, 101 transpose, 110 opposite, 111 reset); latched on start
size  in  3  matrix dimension N, latched on start
scalar  in  8  signed scalar for op 011, latched on start
load_we  in  1  operand write enable
load_sel  in  1  0 = A, 1 = B
load_addr  in  5  operand address (0..24)
load_data  in  8  operand data
rd_addr  in  5  result read address
rd_data  out  8  C[rd_addr], combinational; 0 if rd_addr >= 25
alu_op  out  3  opcode to ALU
alu_r1  out  8  operand 1 to ALU
alu_r2  out  8  operand 2 to ALU
alu_s  out  3  size to ALU (latched N)
alu_outr  in  8  ALU result
busy  out  1  high while a command executes
done  out  1  one-cycle pulse at completion
err  out  1  one-cycle pulse, coincident with done, on an invalid size

Behaviour:
- Reset: state IDLE; A, B and C all 0; busy = 0, done = 0, err = 0; alu_op = 000, alu_r1 = 0, alu_r2 = 0, alu_s = 0; indices i, j, k = 0; acc = 0. Reset is asynchronous and takes effect mid-command, abandoning the command with no partial result guaranteed.
- States: IDLE, RUN, FIN.
- IDLE:
  - load_we writes the selected matrix at load_addr on the clock edge. Addresses >= 25 are ignored.
  - start latches op, size and scalar, then goes to RUN. busy = 1 from the next cycle.
- Writes and start are ignored while busy. A simultaneous load_we and start in IDLE performs the write first, so the command sees the new value.
- Invalid size (0, 6, 7): go directly to FIN with no writes to C. done = 1 and err = 1 for one cycle.
- RUN, elementwise ops (000, 001, 011, 101, 110):
  - One element per cycle, i outer, j inner, from (0,0) to (N-1,N-1).
  - Operand mapping: add/sub use r1 = A[i][j], r2 = B[i][j]. Op 011 uses r1 = A[i][j], r2 = scalar. Transpose uses r1 = A[j][i], r2 = 1. Opposite uses r1 = A[i][j], r2 = -1.
  - C[i][j] <= alu_outr at the end of the same cycle.
  - N*N cycles in RUN.
- RUN, op 010 (multiply):
  - For each (i,j), k runs 0..N-1 with r1 = A[i][k], r2 = B[k][j].
  - sum = (k==0 ? alu_outr : acc + alu_outr), truncated to 8 bits (wrap, no saturation).
  - acc <= sum each cycle. At k = N-1, C[i][j] <= sum and k resets to 0.
  - N³ cycles in RUN.
- RUN, op 100 (det): one cycle; C[0][0] <= alu_outr. No other entries change.
- RUN, op 111 (reset): one cycle; all 25 C entries <= 0. The ALU output is not used.
- C entries outside the N×N window are never written by ops 000–110.
- FIN: one cycle with done = 1 and busy = 0, then IDLE. A start arriving in FIN is ignored.
- alu_op and alu_s hold the latched values while busy, and 000/0 in IDLE. alu_r1 and alu_r2 are 0 outside RUN.
- Latency: start at edge T; busy from T+1; last C write at edge T+cycles; done during the following cycle.

Test Plan:
- Add, N=2: A = {1,2,3,4}, B = {10,20,30,40} at addresses 0,1,5,6 -> C at 0,1,5,6 = {11,22,33,44}; done 5 cycles after start; C[2] = 0.
- Multiply, N=2: A = {1,2,3,4}, B = {5,6,7,8} -> C = {19,22,43,50}; done 9 cycles after start.
- Multiply wrap, N=1: A[0] = 16, B[0] = 16 -> C[0] = 0 (256 truncated). Mult-by-real: A[0] = -3, scalar = 5 -> C[0] = -15.
- Transpose, N=3: A = 0..8 row-major (packed at stride 5) -> C row0 = {0,3,6}, row1 = {1,4,7}, row2 = {2,5,8}. Opposite on the same A -> C[6] = -4.
- Invalid size 6 -> done and err together on the 2nd cycle after start, C unchanged. A start and a load_we pulsed while busy have no effect.
- rst_n asserted mid-multiply -> busy = 0 and all C = 0 immediately. A reset op (111) after an add -> all C = 0, done on the 2nd cycle after start.
